// File: rtl/ulaplus_palette_arbiter_pkg.sv
// Shared types and widths for the ULA+ palette RAM arbiter.
package ulaplus_palette_arbiter_pkg;

    localparam int PAL_ADDR_W = 6;
    localparam int PAL_DATA_W = 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } pal_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INIT,
        GNT_VIDEO,
        GNT_CPU
    } pal_grant_t;

endpackage

// File: rtl/ulaplus_palette_arbiter_init_counter.sv
// Init sweep sequencer: owns the sweep address counter and the INIT/RUN state.
module ulaplus_palette_arbiter_init_counter
    import ulaplus_palette_arbiter_pkg::*;
#(
    parameter int ADDR_W        = PAL_ADDR_W,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] count_o,
    output logic              busy_o
);

    pal_state_t        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;

    // State and sweep address register
    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: one entry per cycle, leave after the last address, restart on start_i
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_INIT: begin
                // Natural wrap takes the counter back to 0 on the exit cycle
                count_d = count_q + 1'b1;
                if (start_i) begin
                    count_d = '0;
                end else if (count_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_i) begin
                    state_d = ST_INIT;
                    count_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign count_o = count_q;
    assign busy_o  = (state_q == ST_INIT);

endmodule

// File: rtl/ulaplus_palette_arbiter.sv
// Single-port ULA+ palette RAM arbiter: init sweep > video lookup > CPU port access.
module ulaplus_palette_arbiter
    import ulaplus_palette_arbiter_pkg::*;
#(
    parameter int                ADDR_W        = PAL_ADDR_W,
    parameter int                DATA_W        = PAL_DATA_W,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter bit                INIT_ON_RESET = 1'b1
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              init_start,
    input  logic              video_req,
    input  logic [ADDR_W-1:0] video_addr,
    output logic [DATA_W-1:0] video_data,
    output logic              video_valid,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rdata_valid,
    output logic              cpu_busy,
    output logic              cpu_overrun,
    output logic              init_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [ADDR_W-1:0] init_cnt;
    pal_grant_t        grant;

    logic              cpu_busy_q, cpu_busy_d;
    logic              cpu_overrun_q, cpu_overrun_d;
    logic              cpu_wr_q, cpu_wr_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [DATA_W-1:0] cpu_wdata_q, cpu_wdata_d;
    logic              vid_vld_q, vid_zero_q, rd_vld_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    ulaplus_palette_arbiter_init_counter #(
        .ADDR_W        (ADDR_W),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init (
        .clk28   (clk28),
        .rst     (rst),
        .start_i (init_start),
        .count_o (init_cnt),
        .busy_o  (init_busy)
    );

    // Grant selection and RAM port drive; nothing reaches the RAM while rst is high
    always_comb begin
        grant     = GNT_NONE;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!rst) begin
            if (init_busy)       grant = GNT_INIT;
            else if (video_req)  grant = GNT_VIDEO;
            else if (cpu_busy_q) grant = GNT_CPU;
        end
        case (grant)
            GNT_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = init_cnt;
                ram_wdata = INIT_VALUE;
            end
            GNT_VIDEO: ram_addr = video_addr;
            GNT_CPU: begin
                ram_addr  = cpu_addr_q;
                ram_we    = cpu_wr_q;
                ram_wdata = cpu_wr_q ? cpu_wdata_q : '0;
            end
            default: ;
        endcase
    end

    // CPU request latch: accept when idle, flag overrun when a request hits a busy latch
    always_comb begin
        cpu_busy_d    = cpu_busy_q;
        cpu_overrun_d = cpu_overrun_q;
        cpu_wr_d      = cpu_wr_q;
        cpu_addr_d    = cpu_addr_q;
        cpu_wdata_d   = cpu_wdata_q;
        if (grant == GNT_CPU) begin
            cpu_busy_d = 1'b0;
        end
        if (cpu_rd_req || cpu_wr_req) begin
            if (cpu_busy_q) begin
                cpu_overrun_d = 1'b1;
            end else begin
                // A simultaneous read+write pulse is taken as a write
                cpu_busy_d  = 1'b1;
                cpu_wr_d    = cpu_wr_req;
                cpu_addr_d  = cpu_addr;
                cpu_wdata_d = cpu_wdata;
            end
        end
    end

    // Control registers and return-path strobes
    always_ff @(posedge clk28) begin
        if (rst) begin
            cpu_busy_q    <= 1'b0;
            cpu_overrun_q <= 1'b0;
            vid_vld_q     <= 1'b0;
            vid_zero_q    <= 1'b0;
            rd_vld_q      <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            cpu_busy_q    <= cpu_busy_d;
            cpu_overrun_q <= cpu_overrun_d;
            // Video always answers one cycle later; ungranted lookups answer zero
            vid_vld_q     <= video_req;
            vid_zero_q    <= (grant != GNT_VIDEO);
            rd_vld_q      <= (grant == GNT_CPU) && !cpu_wr_q;
            if (rd_vld_q) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    // Request payload latch; only meaningful while cpu_busy_q is set
    always_ff @(posedge clk28) begin
        cpu_wr_q    <= cpu_wr_d;
        cpu_addr_q  <= cpu_addr_d;
        cpu_wdata_q <= cpu_wdata_d;
    end

    assign video_valid     = vid_vld_q;
    assign video_data      = (vid_vld_q && !vid_zero_q) ? ram_rdata : '0;
    assign cpu_rdata_valid = rd_vld_q;
    assign cpu_rdata       = rd_vld_q ? ram_rdata : cpu_rdata_q;
    assign cpu_busy        = cpu_busy_q;
    assign cpu_overrun     = cpu_overrun_q;

endmodule

// File: tb/tb_ulaplus_palette_arbiter.sv
// Directed bench for the ULA+ palette arbiter with a behavioural 64x8 synchronous RAM.
module tb_ulaplus_palette_arbiter;

    logic       clk28 = 1'b0;
    logic       rst = 1'b1;
    logic       init_start = 1'b0;
    logic       video_req = 1'b0;
    logic [5:0] video_addr = '0;
    logic [7:0] video_data;
    logic       video_valid;
    logic       cpu_rd_req = 1'b0;
    logic       cpu_wr_req = 1'b0;
    logic [5:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic [7:0] cpu_rdata;
    logic       cpu_rdata_valid;
    logic       cpu_busy;
    logic       cpu_overrun;
    logic       init_busy;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;

    logic [7:0] mem [64];
    int         n_asrt = 0;
    int         n_fail = 0;

    always #5 clk28 = ~clk28;

    ulaplus_palette_arbiter #(
        .ADDR_W        (6),
        .DATA_W        (8),
        .INIT_VALUE    (8'h00),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk28           (clk28),
        .rst             (rst),
        .init_start      (init_start),
        .video_req       (video_req),
        .video_addr      (video_addr),
        .video_data      (video_data),
        .video_valid     (video_valid),
        .cpu_rd_req      (cpu_rd_req),
        .cpu_wr_req      (cpu_wr_req),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_valid (cpu_rdata_valid),
        .cpu_busy        (cpu_busy),
        .cpu_overrun     (cpu_overrun),
        .init_busy       (init_busy),
        .ram_addr        (ram_addr),
        .ram_we          (ram_we),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata)
    );

    // Palette RAM model: read data is undefined (0xFF) in the cycle after a write
    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 8'h5A;
    end

    always @(posedge clk28) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= 8'hFF;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_read(input string tag, input logic [5:0] a, input logic [7:0] exp);
        step();
        cpu_rd_req = 1'b1;
        cpu_addr   = a;
        @(negedge clk28);
        step();
        cpu_rd_req = 1'b0;
        @(negedge clk28);
        chk({tag, "_gnt"}, {ram_we, ram_addr}, {1'b0, a});
        chk({tag, "_busy"}, cpu_busy, 1);
        step();
        @(negedge clk28);
        chk({tag, "_vld"}, cpu_rdata_valid, 1);
        chk({tag, "_data"}, cpu_rdata, exp);
        chk({tag, "_idle"}, cpu_busy, 0);
        step();
        @(negedge clk28);
        chk({tag, "_vld_off"}, cpu_rdata_valid, 0);
        chk({tag, "_hold"}, cpu_rdata, exp);
    endtask

    initial begin
        // Reset values
        step();
        step();
        @(negedge clk28);
        chk("rst_init_busy", init_busy, 1);
        chk("rst_cpu_busy", cpu_busy, 0);
        chk("rst_overrun", cpu_overrun, 0);
        chk("rst_vvalid", video_valid, 0);
        chk("rst_rvalid", cpu_rdata_valid, 0);
        chk("rst_ram", {ram_we, ram_addr, ram_wdata}, 0);
        chk("rst_vdata", video_data, 0);
        chk("rst_rdata", cpu_rdata, 0);

        // Power-on sweep: 64 writes of 0x00 to 0..63
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk28);
            chk("sweep1", {ram_we, ram_addr, ram_wdata}, {1'b1, 6'(i), 8'h00});
            step();
        end
        @(negedge clk28);
        chk("sweep1_done", init_busy, 0);
        chk("sweep1_we_off", ram_we, 0);

        cpu_read("rd5", 6'd5, 8'h00);

        // CPU write 0x10 = 0xE3 on an idle bus
        step();
        cpu_wr_req = 1'b1;
        cpu_addr   = 6'h10;
        cpu_wdata  = 8'hE3;
        @(negedge clk28);
        chk("wr10_idle", ram_we, 0);
        step();
        cpu_wr_req = 1'b0;
        @(negedge clk28);
        chk("wr10_gnt", {ram_we, ram_addr, ram_wdata}, {1'b1, 6'h10, 8'hE3});
        chk("wr10_busy", cpu_busy, 1);
        step();
        @(negedge clk28);
        chk("wr10_done", {cpu_busy, ram_we}, 0);
        cpu_read("rd10", 6'h10, 8'hE3);

        // Video every other cycle, CPU write coinciding with a video request
        step();
        video_req  = 1'b1;
        video_addr = 6'h10;
        cpu_wr_req = 1'b1;
        cpu_addr   = 6'h20;
        cpu_wdata  = 8'h1C;
        @(negedge clk28);
        chk("mix_vid_gnt", {ram_we, ram_addr}, {1'b0, 6'h10});
        step();
        video_req  = 1'b0;
        cpu_wr_req = 1'b0;
        @(negedge clk28);
        chk("mix_vvalid1", {video_valid, video_data}, {1'b1, 8'hE3});
        chk("mix_cpu_gnt", {ram_we, ram_addr, ram_wdata}, {1'b1, 6'h20, 8'h1C});
        step();
        video_req  = 1'b1;
        video_addr = 6'h20;
        @(negedge clk28);
        chk("mix_vvalid_gap", video_valid, 0);
        chk("mix_cpu_done", cpu_busy, 0);
        step();
        video_req = 1'b0;
        @(negedge clk28);
        chk("mix_vvalid2", {video_valid, video_data}, {1'b1, 8'h1C});
        chk("mix_no_overrun", cpu_overrun, 0);

        // Back-to-back CPU reads while video holds the RAM
        step();
        video_req  = 1'b1;
        video_addr = 6'h10;
        cpu_rd_req = 1'b1;
        cpu_addr   = 6'h10;
        @(negedge clk28);
        step();
        cpu_addr = 6'h20;
        @(negedge clk28);
        chk("ovr_busy", cpu_busy, 1);
        chk("ovr_not_yet", cpu_overrun, 0);
        chk("ovr_video", {video_valid, video_data}, {1'b1, 8'hE3});
        step();
        cpu_rd_req = 1'b0;
        @(negedge clk28);
        chk("ovr_set", cpu_overrun, 1);
        chk("ovr_wait_vid", {ram_we, ram_addr}, {1'b0, 6'h10});
        step();
        video_req = 1'b0;
        @(negedge clk28);
        chk("ovr_cpu_gnt", {cpu_busy, ram_we, ram_addr}, {1'b1, 1'b0, 6'h10});
        step();
        @(negedge clk28);
        chk("ovr_rd_vld", cpu_rdata_valid, 1);
        chk("ovr_rd_data", cpu_rdata, 8'hE3);
        chk("ovr_sticky", cpu_overrun, 1);
        chk("ovr_idle", cpu_busy, 0);

        // init_start while a CPU write is pending behind video
        step();
        video_req  = 1'b1;
        video_addr = 6'h10;
        cpu_wr_req = 1'b1;
        cpu_addr   = 6'h30;
        cpu_wdata  = 8'h77;
        @(negedge clk28);
        step();
        cpu_wr_req = 1'b0;
        init_start = 1'b1;
        @(negedge clk28);
        chk("rs_pending", {cpu_busy, init_busy}, {1'b1, 1'b0});
        step();
        init_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk28);
            chk("sweep2", {ram_we, ram_addr, ram_wdata}, {1'b1, 6'(i), 8'h00});
            if (i == 1) chk("sweep2_video", {video_valid, video_data}, {1'b1, 8'h00});
            if (i == 63) chk("sweep2_busy", {cpu_busy, init_busy}, 2'b11);
            step();
            video_req = 1'b0;
        end
        @(negedge clk28);
        chk("sweep2_done", init_busy, 0);
        chk("rs_wr_gnt", {ram_we, ram_addr, ram_wdata}, {1'b1, 6'h30, 8'h77});
        step();
        @(negedge clk28);
        chk("rs_wr_done", cpu_busy, 0);
        cpu_read("rd10_swept", 6'h10, 8'h00);
        cpu_read("rd30", 6'h30, 8'h77);

        // rst while a CPU read is pending
        step();
        video_req  = 1'b1;
        video_addr = 6'h00;
        cpu_rd_req = 1'b1;
        cpu_addr   = 6'h30;
        @(negedge clk28);
        step();
        cpu_rd_req = 1'b0;
        @(negedge clk28);
        chk("mr_busy", cpu_busy, 1);
        step();
        rst       = 1'b1;
        video_req = 1'b0;
        @(negedge clk28);
        chk("mr_ram_quiet", ram_we, 0);
        step();
        rst = 1'b0;
        @(negedge clk28);
        chk("mr_cpu_busy", cpu_busy, 0);
        chk("mr_overrun", cpu_overrun, 0);
        chk("mr_rvalid", cpu_rdata_valid, 0);
        chk("mr_rdata", cpu_rdata, 0);
        chk("mr_init_busy", init_busy, 1);
        chk("mr_sweep0", {ram_we, ram_addr}, {1'b1, 6'd0});
        step();
        @(negedge clk28);
        chk("mr_rvalid2", cpu_rdata_valid, 0);
        chk("mr_sweep1", {ram_we, ram_addr}, {1'b1, 6'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
